// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle execution unit for the RV32M multiply/divide group. An
//   operation is accepted from EX and the front of the pipeline is frozen
//   until a one-cycle done pulse presents the 32-bit result.
//   Multiplies take 2 cycles (one registered 64-bit product). Divides are a
//   32-step restoring shift-subtract on operand magnitudes, with the sign
//   fixup folded into the final result write. Divide-by-zero and signed
//   overflow skip iteration and finish in 1 cycle.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : EX holds a valid M-extension instruction
//   func3  : 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   op1    : rs1 value (forwarded)
//   op2    : rs2 value (forwarded)
//   flush  : abort any operation in flight (wins over start)
//   stall  : freeze IF/ID/EX (combinational)
//   busy   : sequencer not idle
//   done   : one-cycle pulse, result valid
//   result : operation result, held until overwritten by a later operation
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   a_reg;        // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]   b_reg;        // multiplier, or divisor magnitude
    logic [XLEN-1:0]   rem_reg;      // partial remainder
    logic [XLEN-1:0]   result_reg;
    logic [1:0]        func3_reg;    // bit 2 is only needed at accept
    logic              sign_a_reg;   // operand is treated as negative
    logic              sign_b_reg;
    logic [4:0]        count_reg;

    // ---------------- accept-time decode ----------------
    logic              accept;
    logic              is_div;
    logic              div_signed;
    logic              div_by_zero;
    logic              div_overflow;
    logic              special;
    logic [XLEN-1:0]   special_result;
    logic [XLEN-1:0]   op1_mag, op2_mag;

    assign accept       = (state_reg == IDLE) && start && !flush;
    assign is_div       = func3[2];
    assign div_signed   = !func3[0];
    assign div_by_zero  = (op2 == '0);
    assign div_overflow = div_signed && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign special      = is_div && (div_by_zero || div_overflow);
    assign op1_mag      = (div_signed && op1[XLEN-1]) ? -op1 : op1;
    assign op2_mag      = (div_signed && op2[XLEN-1]) ? -op2 : op2;

    always_comb begin
        special_result = '0;
        if (div_by_zero)
            special_result = func3[1] ? op1 : '1;
        else
            special_result = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ---------------- multiply datapath ----------------
    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // ordinary product correct for every signedness combination.
    logic [2*XLEN-1:0] a_ext, b_ext, product;

    assign a_ext   = {{XLEN{sign_a_reg}}, a_reg};
    assign b_ext   = {{XLEN{sign_b_reg}}, b_reg};
    assign product = a_ext * b_ext;

    // ---------------- divide datapath ----------------
    logic [XLEN:0]     rem_shift, diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_step, quot_step, quot_fix, rem_fix, div_result;

    assign rem_shift  = {rem_reg, a_reg[XLEN-1]};
    assign diff       = rem_shift - {1'b0, b_reg};
    assign q_bit      = !diff[XLEN];
    assign rem_step   = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quot_step  = {a_reg[XLEN-2:0], q_bit};
    assign quot_fix   = (sign_a_reg ^ sign_b_reg) ? -quot_step : quot_step;
    assign rem_fix    = sign_a_reg ? -rem_step : rem_step;
    assign div_result = func3_reg[1] ? rem_fix : quot_fix;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = special ? DONE : (is_div ? DIV : MUL);
            MUL:  state_next = DONE;
            DIV:  if (count_reg == 5'd0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            result_reg <= '0;
            func3_reg  <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            count_reg  <= '0;
        end else if (accept) begin
            func3_reg <= func3[1:0];
            count_reg <= 5'd31;
            rem_reg   <= '0;
            if (is_div) begin
                a_reg      <= op1_mag;
                b_reg      <= op2_mag;
                sign_a_reg <= div_signed && op1[XLEN-1];
                sign_b_reg <= div_signed && op2[XLEN-1];
            end else begin
                a_reg      <= op1;
                b_reg      <= op2;
                // MULHU is the only unsigned rs1; MULHSU/MULHU have unsigned rs2
                sign_a_reg <= (func3[1:0] != 2'b11) && op1[XLEN-1];
                sign_b_reg <= !func3[1] && op2[XLEN-1];
            end
            if (special)
                result_reg <= special_result;
        end else if (!flush) begin
            if (state_reg == MUL) begin
                result_reg <= (func3_reg == 2'b00) ? product[XLEN-1:0]
                                                   : product[2*XLEN-1:XLEN];
            end else if (state_reg == DIV) begin
                a_reg     <= quot_step;
                rem_reg   <= rem_step;
                count_reg <= count_reg - 5'd1;
                if (count_reg == 5'd0)
                    result_reg <= div_result;
            end
        end
    end

    assign stall  = accept || (state_reg == MUL) || (state_reg == DIV);
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op1, op2;
    logic        flush;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_seen++;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation at cycle 0 and observe cycles 1..40.
    task automatic run_vec(input vec_t v);
        int          busy_cnt;
        int          done_cnt;
        int          done_cyc;
        int          stall_bad;
        logic [31:0] res;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; stall_bad = 0; res = '0;
        @(posedge clk); #1;
        start = 1'b1; func3 = v.f3; op1 = v.a; op2 = v.b;
        @(negedge clk);
        check({v.name, " stall_c0"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; op1 = 32'h5a5a_5a5a; op2 = 32'h0000_0003;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    res = result;
                end
                if (stall) stall_bad++;
            end else if (busy && !stall) begin
                stall_bad++;
            end
        end
        $display("op %-10s f3=%0d a=0x%08h b=0x%08h -> result=0x%08h done@%0d busy=%0d",
                 v.name, v.f3, v.a, v.b, res, done_cyc, busy_cnt);
        check({v.name, " done_count"}, done_cnt, 32'd1);
        check({v.name, " done_cycle"}, done_cyc, v.lat);
        check({v.name, " result"}, res, v.exp);
        check({v.name, " busy_cycles"}, busy_cnt, v.lat);
        check({v.name, " stall_shape"}, stall_bad, 32'd0);
        check({v.name, " result_held"}, result, v.exp);
    endtask

    initial begin
        int          d0;
        logic [31:0] prev;

        vecs[0]  = '{"MUL",      3'd0, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 2};
        vecs[1]  = '{"MULHU",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[2]  = '{"MULH",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[3]  = '{"MULHSU",   3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2};
        vecs[4]  = '{"MULHU2",   3'd3, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 2};
        vecs[5]  = '{"MULwrap",  3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2};
        vecs[6]  = '{"DIV",      3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33};
        vecs[7]  = '{"REM",      3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33};
        vecs[8]  = '{"DIVU",     3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[9]  = '{"REMU",     3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[10] = '{"DIVnegb",  3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[11] = '{"REMnegb",  3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[12] = '{"DIVnega",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[13] = '{"REMnega",  3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[14] = '{"DIVUbig",  3'd5, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 33};
        vecs[15] = '{"REMUbig",  3'd7, 32'hFFFF_FFFF, 32'd10,        32'd5,         33};
        vecs[16] = '{"DIVUz",    3'd5, 32'd123,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[17] = '{"REMz",     3'd6, 32'd5,         32'd0,         32'd5,         1};
        vecs[18] = '{"DIVz",     3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[19] = '{"REMUz",    3'd7, 32'd9,         32'd0,         32'd9,         1};
        vecs[20] = '{"DIVovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[21] = '{"REMovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

        rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy",   {31'd0, busy},  32'd0);
        check("reset done",   {31'd0, done},  32'd0);
        check("reset stall",  {31'd0, stall}, 32'd0);
        check("reset result", result,         32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Flush at cycle 10 of a DIV; a MUL issued at cycle 12 completes at 14.
        prev = result;
        @(posedge clk); #1 d0 = done_seen;
        start = 1'b1; func3 = 3'd4; op1 = 32'd1000; op2 = 32'd7;   // cycle 0
        @(posedge clk); #1 start = 1'b0;                           // cycle 1
        repeat (8) @(posedge clk);                                 // cycle 9
        @(posedge clk); #1 flush = 1'b1;                           // cycle 10
        @(negedge clk);
        check("flush stall_c10", {31'd0, stall}, 32'd1);
        @(posedge clk); #1 flush = 1'b0;                           // cycle 11
        @(negedge clk);
        check("flush busy_c11",   {31'd0, busy},  32'd0);
        check("flush stall_c11",  {31'd0, stall}, 32'd0);
        check("flush done_c11",   {31'd0, done},  32'd0);
        check("flush result_kept", result, prev);
        $display("flush at c10: busy=%0d stall=%0d result=0x%08h", busy, stall, result);
        run_vec(vecs[0]);
        @(posedge clk); #1;
        check("flush done_total", done_seen - d0, 32'd1);

        // start together with flush in IDLE is not accepted
        start = 1'b1; flush = 1'b1; func3 = 3'd0; op1 = 32'd3; op2 = 32'd3;
        @(negedge clk);
        check("startflush stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("startflush busy", {31'd0, busy}, 32'd0);
        $display("start+flush: busy=%0d", busy);

        // flush landing in DONE does not cancel that cycle's done
        @(posedge clk); #1 start = 1'b1; func3 = 3'd0; op1 = 32'd6; op2 = 32'd9;  // c0
        @(posedge clk); #1 start = 1'b0;                                          // c1
        @(posedge clk); #1 flush = 1'b1;                                          // c2
        @(negedge clk);
        check("flushdone done",   {31'd0, done}, 32'd1);
        check("flushdone result", result, 32'd54);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flushdone after", {31'd0, done | busy}, 32'd0);
        $display("flush in DONE: result=0x%08h", result);

        // start held high: accepted at c0 and again at c3 (cycle after DONE)
        @(posedge clk); #1 d0 = done_seen;
        start = 1'b1; func3 = 3'd0; op1 = 32'd3; op2 = 32'd5;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b2b done_count", done_seen - d0, 32'd2);
        check("b2b result", result, 32'd15);
        $display("back-to-back: dones=%0d result=0x%08h", done_seen - d0, result);

        // second start during a DIV is ignored
        @(posedge clk); #1 d0 = done_seen;
        start = 1'b1; func3 = 3'd5; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk); #1 op1 = 32'd55; func3 = 3'd0;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("ignore done_count", done_seen - d0, 32'd1);
        check("ignore result", result, 32'd14);
        $display("start while busy: dones=%0d result=0x%08h", done_seen - d0, result);

        // reset at cycle 5 of a DIV
        @(posedge clk); #1 d0 = done_seen;
        start = 1'b1; func3 = 3'd5; op1 = 32'd100; op2 = 32'd7;   // c0
        @(posedge clk); #1 start = 1'b0;                          // c1
        repeat (3) @(posedge clk);                                // c4
        @(posedge clk); #1 rst = 1'b1;                            // c5
        @(posedge clk); #1 rst = 1'b0;                            // c6
        @(negedge clk);
        check("rst busy",   {31'd0, busy},  32'd0);
        check("rst done",   {31'd0, done},  32'd0);
        check("rst stall",  {31'd0, stall}, 32'd0);
        check("rst result", result,         32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("rst no_done", done_seen - d0, 32'd0);
        $display("reset mid-DIV: busy=%0d result=0x%08h", busy, result);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M multiply/divide operations (opcode 0110011, func7 0000001) issued from the execute stage.
- Captures operands on start, sequences a registered 2-cycle multiply or a 32-iteration restoring divide, and holds the pipeline via a stall output until the result is ready.
- Returns a one-cycle done pulse with the 32-bit result for the EX/MEM register.
- Supports a synchronous flush for branch mispredict or trap abort.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration counter is 5 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  EX holds a valid M-extension instruction
- func3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  input  32  rs1 value (after forwarding)
- op2  input  32  rs2 value (after forwarding)
- flush  input  1  abort any operation in flight
- stall  output  1  freeze IF/ID/EX; combinational
- busy  output  1  sequencer not in IDLE; registered
- done  output  1  one-cycle pulse, result valid
- result  output  32  operation result; held until next accept

Behaviour:
- Reset: state=IDLE; busy=0; done=0; result=0; counter=0; internal operand/quotient/remainder registers=0.
- States: IDLE, MUL, DIV, DONE.
- Accept: in IDLE with start=1 and flush=0. Latch op1, op2, func3, and operand signs at the edge of cycle N.
- MUL path (func3[2]=0):
  - N+1: state MUL. Compute the 64-bit product from sign-extended operands (MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned) and register it.
  - N+2: state DONE, done=1.
  - result = product[31:0] for MUL, product[63:32] for the others.
- DIV path (func3[2]=1):
  - Use operand magnitudes for signed ops. Counter loads 31.
  - N+1..N+32: state DIV, one restoring shift-subtract step per cycle, counter decrements.
  - The step taken with counter=0 exits to DONE.
  - N+33: DONE, done=1.
  - Sign fixup is applied when result is registered: quotient negated if operand signs differ, remainder takes the dividend sign.
- Special cases are decided at accept and go directly to DONE at N+1, skipping iteration:
  - Divide by zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU result=op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM): DIV result=0x80000000; REM result=0.
- DONE → IDLE unconditionally on the next cycle. A new start can be accepted in the cycle after DONE.
- stall = (state==IDLE & start & ~flush) | (state==MUL) | (state==DIV). stall is low in DONE so the pipeline advances and captures result.
- busy = (state != IDLE).
- start while state != IDLE is ignored; no queueing.
- flush = 1 in any state: next state IDLE; done not asserted; result keeps its old value.
  - flush wins over a same-cycle start.
  - flush while in DONE still lets that cycle's done=1 stand, because done is a registered output of the current state.
- rst during an operation: all registers return to reset values on the next edge, regardless of start or flush.
- done is asserted only in DONE and lasts exactly one cycle.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFA (−6), start at cycle 0: stall=1 in cycles 0–1; done at cycle 2 with result=0xFFFFFFD6; stall=0 at cycle 2.
- MULHU op1=op2=0xFFFFFFFF → result 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU op1=0xFFFFFFFF, op2=2 → 0xFFFFFFFF. Each takes 2 cycles.
- DIV op1=−20 (0xFFFFFFEC), op2=3: done at cycle 33 with result 0xFFFFFFFA. REM with the same operands → 0xFFFFFFFE. DIVU 100/7 → 14; REMU → 2. busy is high for exactly 33 cycles.
- DIVU op2=0 → 0xFFFFFFFF. REM op1=5, op2=0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0. Each has done at cycle 1.
- Start a DIV, then assert flush at cycle 10: state IDLE at cycle 11, no done pulse, stall=0. A MUL started at cycle 12 completes normally at cycle 14.
- Assert rst at cycle 5 of a DIV: busy=done=result=0 next cycle. A second start asserted while busy in a normal DIV is ignored (exactly one done pulse occurs).
